// File: rtl/uart_buf_drain.sv
// uart_buf_drain
//   Reader side of the UART receive ring buffer held in BRAM. A start pulse
//   walks rd_ptr toward the writer's wr_ptr. Each byte is fetched from BRAM
//   and handed to the UART transmitter with a one-cycle transmit strobe. The
//   drain stops when the ring is empty, or (optionally) when a NUL byte is
//   fetched.
//
// Ports
//   CLK, reset_n      clock, synchronous active-low reset
//   start             one-cycle drain request, ignored unless idle
//   wr_ptr            writer's next-write address, compared live
//   ram_addr          BRAM address (= rd_ptr)
//   ram_cs_n/ram_rd_n BRAM select / read strobe, low only in RD
//   ram_data_in       BRAM registered read data, valid the cycle after RD
//   tx_byte/transmit  byte and send strobe to the UART
//   is_transmitting   UART busy
//   busy              high whenever not IDLE
//   done              one-cycle pulse at the end of a drain
//   rd_ptr            next address to read
module uart_buf_drain #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BUF_START   = '0,
  parameter logic [ADDR_WIDTH-1:0] BUF_SIZE    = ADDR_WIDTH'(255),
  parameter bit                    STOP_ON_NUL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs_n,
  output logic                  ram_rd_n,
  input  logic [7:0]            ram_data_in,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  input  logic                  is_transmitting,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_ptr
);

  localparam logic [ADDR_WIDTH-1:0] BUF_LAST = BUF_START + BUF_SIZE;

  typedef enum logic [2:0] {
    IDLE, RD, LATCH, WAITTX, SEND, GAP, ADV, FIN
  } state_t;

  state_t                state, nstate;
  logic [7:0]            byte_q;
  logic                  stop_q;
  logic [ADDR_WIDTH-1:0] rd_nxt;

  assign rd_nxt   = (rd_ptr == BUF_LAST) ? BUF_START : rd_ptr + 1'b1;
  assign ram_addr = rd_ptr;
  assign ram_cs_n = (state != RD);
  assign ram_rd_n = (state != RD);
  assign transmit = (state == SEND);
  assign done     = (state == FIN);
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_ptr  <= BUF_START;
      tx_byte <= '0;
      byte_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        IDLE:   stop_q <= 1'b0;
        LATCH: begin
          byte_q <= ram_data_in;
          stop_q <= STOP_ON_NUL && (ram_data_in == 8'h00);
        end
        WAITTX: if (!is_transmitting) tx_byte <= byte_q;
        ADV:    rd_ptr <= rd_nxt;
        default: ;
      endcase
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:   if (start) nstate = (rd_ptr != wr_ptr) ? RD : FIN;
      RD:     nstate = LATCH;
      // NUL is consumed here: pointer still advances, but nothing is sent.
      LATCH:  nstate = (STOP_ON_NUL && ram_data_in == 8'h00) ? ADV : WAITTX;
      WAITTX: if (!is_transmitting) nstate = SEND;
      SEND:   nstate = GAP;
      // GAP gives the UART a cycle to raise is_transmitting before the
      // next byte can reach WAITTX.
      GAP:    nstate = ADV;
      ADV:    nstate = (stop_q || rd_nxt == wr_ptr) ? FIN : RD;
      FIN:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_buf_drain.sv
// Directed bench for uart_buf_drain. Two instances share clock, reset,
// start, wr_ptr and the BRAM model: dut stops on NUL, dut0 sends NUL as data.
module tb_uart_buf_drain;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_transmitting = 1'b0;
  logic [15:0] wr_ptr = '0;

  logic [15:0] ram_addr, rd_ptr, ram_addr0, rd_ptr0;
  logic        ram_cs_n, ram_rd_n, transmit, busy, done;
  logic        ram_cs_n0, ram_rd_n0, transmit0, busy0, done0;
  logic [7:0]  tx_byte, tx_byte0;
  logic [7:0]  ram_data_in = '0, ram_data_in0 = '0;

  uart_buf_drain #(.STOP_ON_NUL(1'b1)) dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .wr_ptr(wr_ptr),
    .ram_addr(ram_addr), .ram_cs_n(ram_cs_n), .ram_rd_n(ram_rd_n),
    .ram_data_in(ram_data_in), .tx_byte(tx_byte), .transmit(transmit),
    .is_transmitting(is_transmitting), .busy(busy), .done(done), .rd_ptr(rd_ptr));

  uart_buf_drain #(.STOP_ON_NUL(1'b0)) dut0 (
    .CLK(CLK), .reset_n(reset_n), .start(start), .wr_ptr(wr_ptr),
    .ram_addr(ram_addr0), .ram_cs_n(ram_cs_n0), .ram_rd_n(ram_rd_n0),
    .ram_data_in(ram_data_in0), .tx_byte(tx_byte0), .transmit(transmit0),
    .is_transmitting(is_transmitting), .busy(busy0), .done(done0), .rd_ptr(rd_ptr0));

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:255];

  always @(posedge CLK) begin
    if (!ram_cs_n && !ram_rd_n)   ram_data_in  <= mem[ram_addr[7:0]];
    if (!ram_cs_n0 && !ram_rd_n0) ram_data_in0 <= mem[ram_addr0[7:0]];
  end

  int         ncyc = 0, done_cnt = 0, done_cyc = 0, cs_cnt = 0;
  logic [7:0] txq[$], tx0q[$];
  int         txc[$];
  int         total = 0, bad = 0;

  always @(negedge CLK) begin
    ncyc++;
    if (transmit) begin txq.push_back(tx_byte); txc.push_back(ncyc); end
    if (transmit0) tx0q.push_back(tx_byte0);
    if (done) begin done_cnt++; done_cyc = ncyc; end
    if (!ram_cs_n) cs_cnt++;
  end

  // Step to just after the falling edge so the monitor has already run.
  task automatic tick();
    @(negedge CLK); #1;
  endtask

  int ts;
  task automatic pulse_start();
    tick(); start = 1'b1; ts = ncyc;
    tick(); start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    txq.delete(); tx0q.delete(); txc.delete();
  endtask

  task automatic wait_done(input int max);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < max) begin tick(); n++; end
    total++;
    if (done_cnt == d0) begin bad++; $display("FAIL wait_done timeout after %0d cycles", max); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(); tick();
    total++; if (transmit !== 1'b0) begin bad++; $display("FAIL reset_transmit got=%b exp=0", transmit); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (ram_cs_n !== 1'b1 || ram_rd_n !== 1'b1) begin bad++; $display("FAIL reset_ram cs=%b rd=%b exp=1,1", ram_cs_n, ram_rd_n); end
    total++; if (rd_ptr !== 16'h0)  begin bad++; $display("FAIL reset_rd_ptr got=%h exp=0000", rd_ptr); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int d0;
    do_reset();
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; wr_ptr = 16'd3;
    d0 = done_cnt;
    pulse_start(); wait_done(100); repeat (5) tick();
    total++; if (txq.size() != 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", txq.size()); end
    else begin
      total++; if (txq[0] !== 8'h41 || txq[1] !== 8'h42 || txq[2] !== 8'h43) begin
        bad++; $display("FAIL basic_bytes got=%h %h %h exp=41 42 43", txq[0], txq[1], txq[2]); end
      total++; if (txc[0] - ts != 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", txc[0] - ts); end
      total++; if (txc[1] - txc[0] != 6) begin bad++; $display("FAIL basic_period got=%0d exp=6", txc[1] - txc[0]); end
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
    total++; if (rd_ptr !== 16'd3) begin bad++; $display("FAIL basic_rd_ptr got=%h exp=0003", rd_ptr); end
  endtask

  task automatic test_empty();
    int c0;
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
    wr_ptr = 16'd5;
    pulse_start(); wait_done(100); repeat (3) tick();
    total++; if (rd_ptr !== 16'd5) begin bad++; $display("FAIL empty_setup_rd_ptr got=%h exp=0005", rd_ptr); end
    txq.delete(); c0 = cs_cnt;
    pulse_start(); repeat (6) tick();
    total++; if (done_cyc != ts + 1) begin bad++; $display("FAIL empty_done_cycle got=%0d exp=%0d", done_cyc, ts + 1); end
    total++; if (cs_cnt != c0) begin bad++; $display("FAIL empty_cs got=%0d exp=%0d", cs_cnt, c0); end
    total++; if (txq.size() != 0) begin bad++; $display("FAIL empty_transmit got=%0d exp=0", txq.size()); end
  endtask

  task automatic test_nul();
    do_reset();
    mem[0] = 8'h48; mem[1] = 8'h00; mem[2] = 8'h49; wr_ptr = 16'd3;
    pulse_start(); wait_done(100); repeat (25) tick();
    total++; if (txq.size() != 1 || txq[0] !== 8'h48) begin
      bad++; $display("FAIL nul_stop_bytes got_n=%0d exp=1 byte 48", txq.size()); end
    total++; if (rd_ptr !== 16'd2) begin bad++; $display("FAIL nul_stop_rd_ptr got=%h exp=0002", rd_ptr); end
    total++; if (tx0q.size() != 3) begin bad++; $display("FAIL nul_data_count got=%0d exp=3", tx0q.size()); end
    else begin
      total++; if (tx0q[0] !== 8'h48 || tx0q[1] !== 8'h00 || tx0q[2] !== 8'h49) begin
        bad++; $display("FAIL nul_data_bytes got=%h %h %h exp=48 00 49", tx0q[0], tx0q[1], tx0q[2]); end
    end
    total++; if (rd_ptr0 !== 16'd3) begin bad++; $display("FAIL nul_data_rd_ptr got=%h exp=0003", rd_ptr0); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) mem[i] = 8'h80;
    wr_ptr = 16'h00FF;
    pulse_start(); wait_done(2000); repeat (3) tick();
    total++; if (rd_ptr !== 16'h00FF) begin bad++; $display("FAIL wrap_setup_rd_ptr got=%h exp=00ff", rd_ptr); end
    txq.delete();
    mem[255] = 8'h5A; mem[0] = 8'h5B; wr_ptr = 16'h0001;
    pulse_start(); wait_done(100); repeat (3) tick();
    total++; if (txq.size() != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", txq.size()); end
    else begin
      total++; if (txq[0] !== 8'h5A || txq[1] !== 8'h5B) begin
        bad++; $display("FAIL wrap_bytes got=%h %h exp=5a 5b", txq[0], txq[1]); end
    end
    total++; if (rd_ptr !== 16'h0001) begin bad++; $display("FAIL wrap_rd_ptr got=%h exp=0001", rd_ptr); end
  endtask

  task automatic test_stall();
    int tm;
    do_reset();
    mem[0] = 8'h77; wr_ptr = 16'd1; is_transmitting = 1'b1;
    pulse_start(); tick(); tick();
    repeat (50) tick();
    total++; if (txq.size() != 0) begin bad++; $display("FAIL stall_held got=%0d exp=0", txq.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b exp=1", busy); end
    is_transmitting = 1'b0; tm = ncyc;
    wait_done(20); repeat (3) tick();
    total++; if (txq.size() != 1) begin bad++; $display("FAIL stall_count got=%0d exp=1", txq.size()); end
    else begin
      total++; if (txc[0] != tm + 1) begin bad++; $display("FAIL stall_release got=%0d exp=%0d", txc[0], tm + 1); end
      total++; if (txq[0] !== 8'h77) begin bad++; $display("FAIL stall_byte got=%h exp=77", txq[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int n, d0;
    do_reset();
    mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h13; wr_ptr = 16'd3;
    pulse_start();
    n = 0;
    while (txq.size() == 0 && n < 20) begin tick(); n++; end
    reset_n = 1'b0; tick();
    total++; if (transmit !== 1'b0 || busy !== 1'b0 || rd_ptr !== 16'h0) begin
      bad++; $display("FAIL rst_send got tx=%b busy=%b rd=%h exp=0 0 0000", transmit, busy, rd_ptr); end
    reset_n = 1'b1; n = txq.size(); d0 = done_cnt;
    repeat (20) tick();
    total++; if (txq.size() != n || done_cnt != d0) begin
      bad++; $display("FAIL rst_send_after got pulses=%0d done=%0d exp=%0d %0d", txq.size(), done_cnt, n, d0); end

    is_transmitting = 1'b1; txq.delete();
    pulse_start(); repeat (3) tick();
    reset_n = 1'b0; tick();
    total++; if (transmit !== 1'b0 || busy !== 1'b0 || rd_ptr !== 16'h0) begin
      bad++; $display("FAIL rst_wait got tx=%b busy=%b rd=%h exp=0 0 0000", transmit, busy, rd_ptr); end
    reset_n = 1'b1; is_transmitting = 1'b0;
    repeat (20) tick();
    total++; if (txq.size() != 0) begin bad++; $display("FAIL rst_wait_after got=%0d exp=0", txq.size()); end
  endtask

  task automatic test_back_to_back();
    int d0;
    do_reset();
    mem[0] = 8'h21; mem[1] = 8'h22; wr_ptr = 16'd2;
    d0 = done_cnt;
    pulse_start(); tick(); pulse_start();
    wait_done(100); repeat (30) tick();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", done_cnt - d0); end
    total++; if (txq.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", txq.size()); end
    total++; if (tx_byte !== 8'h22) begin bad++; $display("FAIL b2b_hold got=%h exp=22", tx_byte); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_empty();
    test_nul();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
